// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard control for the 5-stage MIPS pipeline: shadow EX/MEM/WB
// destination slots, registered EX operand selects, load-use and HI/LO stalls.
module fwd_hazard_ctrl #(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_UseRs,
  input  logic       ID_UseRt,
  input  logic       ID_RegWrite,
  input  logic [4:0] ID_WriteReg,
  input  logic       ID_MemRead,
  input  logic       ID_MulDivStart,
  input  logic       ID_UseHiLo,
  input  logic       ID_Flush,
  output logic [1:0] AluSrcA_Sel,
  output logic [1:0] AluSrcB_Sel,
  output logic       Stall,
  output logic       EX_Bubble,
  output logic       MulDivBusy
);

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [4:0] write_reg;
    logic       mem_read;
  } slot_t;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MULDIV_LAT);

  slot_t            ex_q, mem_q, wb_q, ex_d;
  logic [1:0]       sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             load_use, hilo_hazard, stall, bubble, start_acc;
  logic             unused_slot_bits;

  // Register $0 is hard-wired to zero, so it never has a producer to forward from.
  function automatic logic writes_reg(input slot_t s, input logic [4:0] r);
    return s.valid && s.reg_write && (s.write_reg == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem,
                                         input logic [4:0] r, input logic use_r);
    if (use_r && writes_reg(ex, r))       return SEL_MEM;
    else if (use_r && writes_reg(mem, r)) return SEL_WB;
    else                                  return SEL_REG;
  endfunction

  always_comb begin
    load_use    = ex_q.mem_read &&
                  ((ID_UseRs && writes_reg(ex_q, ID_rs)) ||
                   (ID_UseRt && writes_reg(ex_q, ID_rt)));
    hilo_hazard = busy_q && ID_UseHiLo;
    stall       = !ID_Flush && (load_use || hilo_hazard);
    bubble      = stall || ID_Flush;
    start_acc   = ID_MulDivStart && !bubble;
  end

  always_comb begin
    ex_d           = '0;
    ex_d.valid     = 1'b1;
    ex_d.reg_write = ID_RegWrite;
    ex_d.write_reg = ID_WriteReg;
    ex_d.mem_read  = ID_MemRead;
    if (bubble) ex_d = '0;

    sel_a_d = SEL_REG;
    sel_b_d = SEL_REG;
    if (!bubble) begin
      sel_a_d = fwd_sel(ex_q, mem_q, ID_rs, ID_UseRs);
      sel_b_d = fwd_sel(ex_q, mem_q, ID_rt, ID_UseRt);
    end

    // A start is only accepted while idle; a start while busy stalls on HI/LO.
    cnt_d = cnt_q;
    if (start_acc)            cnt_d = LAT;
    else if (cnt_q != '0)     cnt_d = cnt_q - CNT_W'(1);
    busy_d = (cnt_d != '0);
  end

  // ---- ID -> EX boundary: shadow slots, operand selects, MULT/DIV counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      sel_a_q <= SEL_REG;
      sel_b_q <= SEL_REG;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // The WB slot and the MEM load flag are tracked for completeness of the shadow pipe only.
  assign unused_slot_bits = ^{wb_q, mem_q.mem_read};

  assign AluSrcA_Sel = sel_a_q;
  assign AluSrcB_Sel = sel_b_q;
  assign Stall       = stall;
  assign EX_Bubble   = bubble;
  assign MulDivBusy  = busy_q;

endmodule
